// File: rtl/piso_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_bit_serializer
// Brief    : Parallel-in serial-out shifter with a one-word holding register,
//            bit-rate strobe and gapless back-to-back word streaming.
// Revision : 1.0
// ============================================================================
module piso_bit_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              bit_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              byte_done,
    output logic              busy
);

    localparam int                c_CNT_W = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_sh;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_hold;
    logic                r_hold_full;
    logic                r_ser_out;
    logic                r_ser_valid;
    logic                r_byte_done;

    logic                w_accept;
    logic                w_first_bit;
    logic [DATA_W-1:0]   w_sh_next;

    // The first-bit end of the shifter depends on the bit order
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_first_bit = r_sh[DATA_W-1];
            assign w_sh_next   = {r_sh[DATA_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_first_bit = r_sh[0];
            assign w_sh_next   = {1'b0, r_sh[DATA_W-1:1]};
        end
    endgenerate

    assign w_accept  = in_valid && !r_hold_full;
    assign in_ready  = !r_hold_full;
    assign busy      = (r_state == ST_SHIFT) || r_hold_full;
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign byte_done = r_byte_done;

    // Accepts only happen with the holding register empty and loads only
    // with it full, so the two never contend for r_hold_full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_byte_done <= 1'b0;

            if (w_accept) begin
                r_hold      <= in_data;
                r_hold_full <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_hold_full) begin
                        r_sh        <= r_hold;
                        r_hold_full <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_en) begin
                        r_ser_out   <= w_first_bit;
                        r_ser_valid <= 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_byte_done <= 1'b1;
                            r_cnt       <= '0;
                            if (r_hold_full) begin
                                r_sh        <= r_hold;
                                r_hold_full <= 1'b0;
                            end else begin
                                r_sh    <= w_sh_next;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_sh  <= w_sh_next;
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_bit_serializer
// Brief    : Directed self-checking bench for piso_bit_serializer.
// Revision : 1.0
// ============================================================================
module tb_piso_bit_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       bit_en;
    logic       ser_out;
    logic       ser_valid;
    logic       byte_done;
    logic       busy;

    logic [7:0] l_in_data;
    logic       l_in_valid;
    logic       l_in_ready;
    logic       l_ser_out;
    logic       l_ser_valid;
    logic       l_byte_done;
    logic       l_busy;

    logic [2:0] det_sh;
    logic       det_dout;

    int vectors;
    int miscompares;

    piso_bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .bit_en(bit_en), .ser_out(ser_out),
        .ser_valid(ser_valid), .byte_done(byte_done), .busy(busy)
    );

    piso_bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .in_data(l_in_data), .in_valid(l_in_valid),
        .in_ready(l_in_ready), .bit_en(bit_en), .ser_out(l_ser_out),
        .ser_valid(l_ser_valid), .byte_done(l_byte_done), .busy(l_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream 1101 pattern detector fed by the serial stream
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            det_sh   <= 3'b000;
            det_dout <= 1'b0;
        end else begin
            det_dout <= 1'b0;
            if (ser_valid) begin
                det_sh   <= {det_sh[1:0], ser_out};
                det_dout <= ({det_sh, ser_out} == 4'b1101);
            end
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input string tag, input logic [7:0] w);
        chk({tag, "_ready"}, in_ready, 1'b1);
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_cycle(input string tag);
        tick();
        chk({tag, "_load_valid"}, ser_valid, 1'b0);
    endtask

    task automatic step_bit(input string tag, input logic b, input logic d);
        tick();
        chk({tag, "_valid"}, ser_valid, 1'b1);
        chk({tag, "_bit"}, ser_out, b);
        chk({tag, "_done"}, byte_done, d);
    endtask

    task automatic run_word(input string tag, input logic [7:0] w);
        for (int i = 0; i < 8; i++) step_bit(tag, w[7-i], i == 7);
    endtask

    initial begin
        logic [7:0] seq;
        int         nvalid;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bit_en      = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        l_in_valid  = 1'b0;
        l_in_data   = 8'h00;

        // Reset state
        #2;
        chk("rst_valid", ser_valid, 1'b0);
        chk("rst_out", ser_out, 1'b0);
        chk("rst_done", byte_done, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // Single word D0, detector fires one cycle after 4th bit
        send_word("d0", 8'hD0);
        chk("d0_held_ready", in_ready, 1'b0);
        chk("d0_held_busy", busy, 1'b1);
        load_cycle("d0");
        seq = 8'b1101_0000;
        for (int i = 0; i < 8; i++) begin
            step_bit("d0", seq[7-i], i == 7);
            if (i == 3) chk("d0_det_early", det_dout, 1'b0);
            if (i == 4) chk("d0_det_dout", det_dout, 1'b1);
        end
        tick();
        chk("d0_end_valid", ser_valid, 1'b0);
        chk("d0_end_busy", busy, 1'b0);

        // A5 then 3C back-to-back, second word held mid-stream
        send_word("a5", 8'hA5);
        load_cycle("a5");
        in_data  = 8'h3C;
        in_valid = 1'b1;
        seq = 8'b1010_0101;
        step_bit("a5", seq[7], 1'b0);
        in_valid = 1'b0;
        chk("a5_hold_ready", in_ready, 1'b0);
        for (int i = 1; i < 8; i++) step_bit("a5", seq[7-i], i == 7);
        seq = 8'b0011_1100;
        run_word("3c", seq);
        tick();
        chk("3c_end_valid", ser_valid, 1'b0);

        // FF with bit_en on alternate cycles
        send_word("ff", 8'hFF);
        load_cycle("ff");
        for (int c = 0; c < 16; c++) begin
            bit_en = (c % 2 == 0);
            tick();
            chk("ff_valid", ser_valid, (c % 2 == 0));
            chk("ff_bit", ser_out, (c % 2 == 0));
            chk("ff_done", byte_done, (c == 14));
        end
        bit_en = 1'b1;
        tick();
        chk("ff_end_busy", busy, 1'b0);

        // Backpressure: 55 shifting, 11 held, 22 presented continuously
        send_word("bp55", 8'h55);
        load_cycle("bp55");
        in_data  = 8'h11;
        in_valid = 1'b1;
        seq = 8'b0101_0101;
        step_bit("bp55", seq[7], 1'b0);
        in_data = 8'h22;
        for (int i = 1; i < 8; i++) begin
            chk("bp_ready_low", in_ready, 1'b0);
            step_bit("bp55", seq[7-i], i == 7);
        end
        chk("bp_ready_after_load", in_ready, 1'b1);
        seq = 8'b0001_0001;
        step_bit("bp11", seq[7], 1'b0);
        in_valid = 1'b0;
        chk("bp22_held_ready", in_ready, 1'b0);
        for (int i = 1; i < 8; i++) step_bit("bp11", seq[7-i], i == 7);
        seq = 8'b0010_0010;
        run_word("bp22", seq);
        tick();
        chk("bp_end_valid", ser_valid, 1'b0);
        chk("bp_end_busy", busy, 1'b0);

        // Reset after 3 bits of F0 with a held word pending
        send_word("f0", 8'hF0);
        load_cycle("f0");
        in_data  = 8'hAA;
        in_valid = 1'b1;
        step_bit("f0", 1'b1, 1'b0);
        in_valid = 1'b0;
        step_bit("f0", 1'b1, 1'b0);
        step_bit("f0", 1'b1, 1'b0);
        chk("f0_busy_pre", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("f0_rst_valid", ser_valid, 1'b0);
        chk("f0_rst_out", ser_out, 1'b0);
        chk("f0_rst_ready", in_ready, 1'b1);
        chk("f0_rst_busy", busy, 1'b0);
        tick();
        reset  = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (ser_valid) nvalid++;
        end
        vectors++;
        assert (nvalid == 0) else begin
            miscompares++;
            $error("FAIL f0_no_bits observed=%0d expected=0", nvalid);
        end
        chk("f0_idle_busy", busy, 1'b0);
        send_word("r96", 8'h96);
        load_cycle("r96");
        seq = 8'b1001_0110;
        run_word("r96", seq);

        // LSB-first instance, 0B
        l_in_data  = 8'h0B;
        l_in_valid = 1'b1;
        tick();
        l_in_valid = 1'b0;
        tick();
        chk("l0b_load_valid", l_ser_valid, 1'b0);
        seq = 8'b1101_0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("l0b_valid", l_ser_valid, 1'b1);
            chk("l0b_bit", l_ser_out, seq[7-i]);
            chk("l0b_done", l_byte_done, i == 7);
        end
        tick();
        chk("l0b_end_busy", l_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
